// File: rtl/csr_counters.sv
// csr_counters: CSR external-bus responder holding mcycle/minstret, their user shadows and mcountinhibit.
// Define CSR_COUNTERS_TIMER_EN to add mtimecmp (0x7C0/0x7C1) and the machine timer interrupt.
module csr_counters #(
   parameter int         CNT_W      = 64,
   parameter logic [2:0] INHIBIT_RV = 3'b000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [11:0] i_addr,
   input  logic [31:0] i_wr_data,
   input  logic        i_wr,
   input  logic        i_rd,
   input  logic        i_retire,
   output logic [31:0] o_rd_data,
   output logic        o_hit,
   output logic        o_timer_irq
);
   localparam int HALF_W = CNT_W / 2;
   localparam int N_CNT  = 2;

   logic                        cy_inh_reg;
   logic                        ir_inh_reg;
   logic [N_CNT-1:0]            inc_en;
   logic [N_CNT-1:0][CNT_W-1:0] cnt_all;
   logic                        unused_rd;

   // Reads are purely address-decoded, so the read strobe carries no information here.
   assign unused_rd = i_rd;

   assign inc_en = {i_retire & ~ir_inh_reg, ~cy_inh_reg};

   // Counter 0 is mcycle (0xB00/0xB80), counter 1 is minstret (0xB02/0xB82).
   genvar gi;
   generate
      for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
         localparam logic [11:0] ADDR_LO = 12'hB00 + 12'(2 * gi);
         localparam logic [11:0] ADDR_HI = ADDR_LO + 12'h080;

         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;
         logic             wr_lo;
         logic             wr_hi;

         assign wr_lo = i_wr && (i_addr == ADDR_LO);
         assign wr_hi = i_wr && (i_addr == ADDR_HI);

         // A half write replaces the whole increment for that cycle.
         always_comb begin
            cnt_next = cnt_reg + CNT_W'(inc_en[gi]);
            if (wr_lo)
               cnt_next = {cnt_reg[CNT_W-1:HALF_W], i_wr_data};
            else if (wr_hi)
               cnt_next = {i_wr_data, cnt_reg[HALF_W-1:0]};
         end

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
               cnt_reg <= '0;
            else
               cnt_reg <= cnt_next;
         end

         assign cnt_all[gi] = cnt_reg;
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cy_inh_reg <= INHIBIT_RV[0];
         ir_inh_reg <= INHIBIT_RV[2];
      end else if (i_wr && (i_addr == 12'h320)) begin
         cy_inh_reg <= i_wr_data[0];
         ir_inh_reg <= i_wr_data[2];
      end
   end

`ifdef CSR_COUNTERS_TIMER_EN
   logic [CNT_W-1:0] mtimecmp_reg;
   logic             timer_irq_reg;

   // Compare uses pre-update values, giving one cycle of latency on the interrupt.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mtimecmp_reg  <= '1;
         timer_irq_reg <= 1'b0;
      end else begin
         timer_irq_reg <= (cnt_all[0] >= mtimecmp_reg);
         if (i_wr && (i_addr == 12'h7C0))
            mtimecmp_reg[HALF_W-1:0] <= i_wr_data;
         else if (i_wr && (i_addr == 12'h7C1))
            mtimecmp_reg[CNT_W-1:HALF_W] <= i_wr_data;
      end
   end

   assign o_timer_irq = timer_irq_reg;
`else
   assign o_timer_irq = 1'b0;
`endif

   always_comb begin
      o_rd_data = '0;
      o_hit     = 1'b1;
      case (i_addr)
         12'hB00, 12'hC00: o_rd_data = cnt_all[0][HALF_W-1:0];
         12'hB80, 12'hC80: o_rd_data = cnt_all[0][CNT_W-1:HALF_W];
         12'hB02, 12'hC02: o_rd_data = cnt_all[1][HALF_W-1:0];
         12'hB82, 12'hC82: o_rd_data = cnt_all[1][CNT_W-1:HALF_W];
         12'h320:          o_rd_data = {29'b0, ir_inh_reg, 1'b0, cy_inh_reg};
`ifdef CSR_COUNTERS_TIMER_EN
         12'h7C0:          o_rd_data = mtimecmp_reg[HALF_W-1:0];
         12'h7C1:          o_rd_data = mtimecmp_reg[CNT_W-1:HALF_W];
`endif
         default:          o_hit     = 1'b0;
      endcase
   end

endmodule
